// File: rtl/fwd_scoreboard_unit.sv
// fwd_scoreboard_unit: operand forwarding over live writeback plus a writeback history, with a pending-write stall scoreboard
// Ports: clk, reset (async, active-high); rd_idx/rd_use/rf_data -> rd_data per read port;
// iss_en/iss_idx track issuing destinations; wb_en/wb_idx/wb_data retire them; stall holds decode.
// Optional macro FWD_STALL_CNT_EN adds the saturating stall_cycles counter output.
module fwd_scoreboard_unit #(
  parameter int DATA_W     = 32,
  parameter int IDX_W      = 4,
  parameter int RD_PORTS   = 2,
  parameter int HIST_DEPTH = 2,
  parameter int PEND_W     = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [RD_PORTS*IDX_W-1:0]  rd_idx,
  input  logic [RD_PORTS-1:0]        rd_use,
  input  logic [RD_PORTS*DATA_W-1:0] rf_data,
  output logic [RD_PORTS*DATA_W-1:0] rd_data,
  input  logic                       iss_en,
  input  logic [IDX_W-1:0]           iss_idx,
  input  logic                       wb_en,
  input  logic [IDX_W-1:0]           wb_idx,
  input  logic [DATA_W-1:0]          wb_data,
  output logic                       stall
`ifdef FWD_STALL_CNT_EN
  ,
  output logic [31:0]                stall_cycles
`endif
);
  localparam int NREG = 1 << IDX_W;
  localparam logic [PEND_W-1:0] PMAX = '1;
  logic [PEND_W-1:0] pend [NREG];
  logic hv [HIST_DEPTH];
  logic [IDX_W-1:0] hidx [HIST_DEPTH];
  logic [DATA_W-1:0] hdata [HIST_DEPTH];
  logic [RD_PORTS-1:0] rd_haz;
  logic [NREG-1:0] inc, dec;
  logic iss_full, iss_ok;
  // A writeback to the same register in this cycle frees a slot, so a full counter does not block.
  assign iss_full = iss_en && pend[iss_idx] == PMAX && !(wb_en && wb_idx == iss_idx);
  assign stall = |rd_haz || iss_full;
  assign iss_ok = iss_en && !stall;
  for (genvar p = 0; p < RD_PORTS; p++) begin : g_port
    logic [IDX_W-1:0] idx;
    logic live;
    logic [DATA_W-1:0] fwd;
    assign idx = rd_idx[p*IDX_W +: IDX_W];
    assign live = wb_en && wb_idx == idx;
    assign rd_haz[p] = rd_use[p] && pend[idx] != '0 && !live;
    // Walk oldest to newest so the youngest matching entry wins; the live writeback overrides all.
    always_comb begin
      fwd = rf_data[p*DATA_W +: DATA_W];
      for (int k = HIST_DEPTH - 1; k >= 0; k--) fwd = (hv[k] && hidx[k] == idx) ? hdata[k] : fwd;
      fwd = live ? wb_data : fwd;
    end
    assign rd_data[p*DATA_W +: DATA_W] = fwd;
  end
  always_comb begin
    for (int r = 0; r < NREG; r++) begin
      inc[r] = iss_ok && iss_idx == IDX_W'(r);
      dec[r] = wb_en && wb_idx == IDX_W'(r);
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < HIST_DEPTH; k++) begin
        hv[k] <= 1'b0;
        hidx[k] <= '0;
        hdata[k] <= '0;
      end
    end else begin
      hv[0] <= wb_en;
      hidx[0] <= wb_idx;
      hdata[0] <= wb_data;
      for (int k = 1; k < HIST_DEPTH; k++) begin
        hv[k] <= hv[k-1];
        hidx[k] <= hidx[k-1];
        hdata[k] <= hdata[k-1];
      end
    end
  end
  // Simultaneous issue and writeback to one register cancel; decrement saturates at zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int r = 0; r < NREG; r++) pend[r] <= '0;
    end else begin
      for (int r = 0; r < NREG; r++) begin
        if (inc[r] && !dec[r]) pend[r] <= pend[r] + PEND_W'(1);
        else if (dec[r] && !inc[r] && pend[r] != '0) pend[r] <= pend[r] - PEND_W'(1);
      end
    end
  end
`ifdef FWD_STALL_CNT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) stall_cycles <= '0;
    else if (stall && stall_cycles != '1) stall_cycles <= stall_cycles + 32'd1;
  end
`endif
endmodule

// File: tb/tb_fwd_scoreboard_unit.sv
// tb_fwd_scoreboard_unit: directed stimulus with a queue/array reference model checked every cycle
module tb_fwd_scoreboard_unit;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [7:0] rd_idx = '0;
  logic [1:0] rd_use = '0;
  logic [63:0] rf_data = '0;
  logic [63:0] rd_data;
  logic iss_en = 1'b0;
  logic [3:0] iss_idx = '0;
  logic wb_en = 1'b0;
  logic [3:0] wb_idx = '0;
  logic [31:0] wb_data = '0;
  logic stall;
  logic [31:0] sc_dut;
  int n_tests = 0;
  int n_fail = 0;
  typedef struct {bit v; logic [3:0] i; logic [31:0] d;} he_t;
  he_t hq[$];
  int pend_m [16];
  int scnt_m = 0;

  fwd_scoreboard_unit dut (
    .clk(clk), .reset(reset), .rd_idx(rd_idx), .rd_use(rd_use), .rf_data(rf_data),
    .rd_data(rd_data), .iss_en(iss_en), .iss_idx(iss_idx), .wb_en(wb_en), .wb_idx(wb_idx),
    .wb_data(wb_data), .stall(stall)
`ifdef FWD_STALL_CNT_EN
    , .stall_cycles(sc_dut)
`endif
  );
`ifndef FWD_STALL_CNT_EN
  assign sc_dut = '0;
`endif

  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    n_tests++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", n, a, e, $time);
    end
  endtask

  always @(negedge clk) begin
    logic [31:0] e;
    logic [3:0] idx;
    bit es, live, acc;
    if (reset) begin
      foreach (pend_m[r]) pend_m[r] = 0;
      hq.delete();
      scnt_m = 0;
    end
    es = 0;
    for (int p = 0; p < 2; p++) begin
      idx = rd_idx[p*4 +: 4];
      live = wb_en && wb_idx == idx;
      e = rf_data[p*32 +: 32];
      if (live) e = wb_data;
      else foreach (hq[k]) if (hq[k].v && hq[k].i == idx) begin e = hq[k].d; break; end
      chk($sformatf("model rd_data[%0d]", p), rd_data[p*32 +: 32], e);
      if (rd_use[p] && pend_m[idx] != 0 && !live) es = 1;
    end
    if (iss_en && pend_m[iss_idx] == 3 && !(wb_en && wb_idx == iss_idx)) es = 1;
    chk("model stall", {31'b0, stall}, {31'b0, es});
`ifdef FWD_STALL_CNT_EN
    chk("model stall_cycles", sc_dut, scnt_m);
`endif
    if (!reset) begin
      acc = iss_en && !es;
      if (!(acc && wb_en && wb_idx == iss_idx)) begin
        if (acc) pend_m[iss_idx]++;
        if (wb_en && pend_m[wb_idx] > 0) pend_m[wb_idx]--;
      end
      hq.push_front('{wb_en, wb_idx, wb_data});
      if (hq.size() > 2) void'(hq.pop_back());
      if (es && scnt_m != 32'hFFFF_FFFF) scnt_m++;
    end
  end

  task automatic drv(input logic [3:0] i0, input logic [3:0] i1, input logic [1:0] u,
                     input logic [31:0] r0, input logic [31:0] r1, input logic ie,
                     input logic [3:0] ii, input logic we, input logic [3:0] wi, input logic [31:0] wd);
    @(posedge clk);
    #1;
    rd_idx = {i1, i0};
    rd_use = u;
    rf_data = {r1, r0};
    iss_en = ie;
    iss_idx = ii;
    wb_en = we;
    wb_idx = wi;
    wb_data = wd;
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    drv(3, 5, 0, 32'h11, 32'h22, 0, 0, 0, 0, 0);
    chk("reset rd0", rd_data[31:0], 32'h11);
    chk("reset rd1", rd_data[63:32], 32'h22);
    chk("reset stall", {31'b0, stall}, 0);
    drv(3, 5, 0, 32'h11, 32'h22, 1, 3, 0, 0, 0);
    chk("issue3 stall", {31'b0, stall}, 0);
    drv(3, 5, 1, 32'h11, 32'h22, 0, 0, 0, 0, 0);
    chk("raw c2 stall", {31'b0, stall}, 1);
    drv(3, 5, 1, 32'h11, 32'h22, 0, 0, 0, 0, 0);
    chk("raw c3 stall", {31'b0, stall}, 1);
    drv(3, 5, 1, 32'h11, 32'h22, 0, 0, 1, 3, 32'hABCD);
    chk("wb live stall", {31'b0, stall}, 0);
    chk("wb live rd0", rd_data[31:0], 32'hABCD);
    drv(3, 5, 1, 32'h11, 32'h22, 0, 0, 0, 0, 0);
    chk("hist0 rd0", rd_data[31:0], 32'hABCD);
    chk("hist0 stall", {31'b0, stall}, 0);
    drv(3, 7, 0, 32'h11, 32'h77, 0, 0, 1, 7, 32'h1);
    drv(3, 7, 0, 32'h11, 32'h77, 0, 0, 1, 7, 32'h2);
    drv(7, 7, 0, 32'h70, 32'h77, 0, 0, 0, 0, 0);
    chk("youngest rd0", rd_data[31:0], 32'h2);
    chk("youngest rd1", rd_data[63:32], 32'h2);
    drv(7, 7, 0, 32'h70, 32'h77, 0, 0, 0, 0, 0);
    chk("hist1 rd0", rd_data[31:0], 32'h2);
    drv(7, 7, 0, 32'h70, 32'h77, 0, 0, 0, 0, 0);
    chk("aged out rd0", rd_data[31:0], 32'h70);
    chk("aged out rd1", rd_data[63:32], 32'h77);
    for (int i = 0; i < 3; i++) begin
      drv(0, 1, 0, 0, 0, 1, 9, 0, 0, 0);
      chk("issue9 accept", {31'b0, stall}, 0);
    end
    drv(0, 1, 0, 0, 0, 1, 9, 0, 0, 0);
    chk("issue full stall", {31'b0, stall}, 1);
    drv(0, 1, 0, 0, 0, 1, 9, 0, 0, 0);
    chk("issue full hold", {31'b0, stall}, 1);
    drv(0, 1, 0, 0, 0, 1, 9, 1, 9, 32'h99);
    chk("full with wb", {31'b0, stall}, 0);
    drv(0, 1, 0, 0, 0, 1, 9, 0, 0, 0);
    chk("pend stays max", {31'b0, stall}, 1);
    for (int i = 0; i < 3; i++) drv(0, 1, 0, 0, 0, 0, 0, 1, 9, 32'h90 + i);
    drv(9, 1, 1, 0, 0, 0, 0, 0, 0, 0);
    chk("drained 9", {31'b0, stall}, 0);
    drv(0, 1, 0, 0, 0, 0, 0, 1, 4, 32'h44);
    drv(4, 1, 1, 32'h40, 0, 0, 0, 0, 0, 0);
    chk("wb underflow stall", {31'b0, stall}, 0);
    drv(0, 1, 0, 0, 0, 1, 2, 0, 0, 0);
    drv(0, 1, 0, 0, 0, 1, 2, 0, 0, 0);
    drv(2, 1, 1, 32'h20, 0, 0, 0, 0, 0, 0);
    chk("pend2 stall", {31'b0, stall}, 1);
    @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    chk("reset async stall", {31'b0, stall}, 0);
    chk("reset async rd0", rd_data[31:0], 32'h20);
    drv(2, 1, 1, 32'h20, 0, 0, 0, 0, 0, 0);
    reset = 1'b0;
    drv(2, 1, 1, 32'h20, 0, 0, 0, 0, 0, 0);
    chk("after reset stall", {31'b0, stall}, 0);
    drv(0, 1, 0, 0, 0, 1, 5, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      drv(5, 1, 1, 32'h50, 0, 0, 0, 0, 0, 0);
      chk("hold hazard", {31'b0, stall}, 1);
    end
    drv(5, 1, 0, 32'h50, 0, 0, 0, 0, 0, 0);
    chk("hazard released", {31'b0, stall}, 0);
`ifdef FWD_STALL_CNT_EN
    chk("stall_cycles 5", sc_dut, 32'd5);
    @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    chk("stall_cycles reset", sc_dut, 32'd0);
    drv(5, 1, 0, 32'h50, 0, 0, 0, 0, 0, 0);
    reset = 1'b0;
`endif
    drv(5, 1, 0, 32'h50, 0, 0, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
